contador_monitor: RTL

- Receive-side checker for the up/down "bouncing" counter stream (0→MAX→0, turnaround without repeating the endpoint).
- Samples the count bus on each enabled clock, acquires lock on the sequence, and tracks direction.
- Predicts the next value, flags mismatches, and counts completed periods.
- Sits at the consuming end of the counter output, in the bench or in a downstream block.

---
 rtl/contador_pkg.sv | 37 +++
 rtl/contador_predictor.sv | 21 ++
 rtl/contador_monitor.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/contador_pkg.sv
// Shared types and the bouncing-counter step function for the contador monitor.
// Both the RTL predictor and the bench counter model use next_step().
package contador_pkg;

  typedef enum logic [1:0] {
    UNSYNC,
    ACQUIRE,
    LOCKED
  } state_t;

  // Value and direction arriving at that value (0 = up, 1 = down).
  typedef struct packed {
    logic [31:0] value;
    logic        dir;
  } step_t;

  localparam int unsigned DEF_WIDTH = 4;

  function automatic logic [31:0] max_of(input int unsigned width);
    return (32'd1 << width) - 32'd1;
  endfunction

  // The endpoint is never repeated: at MAX the next value is MAX-1, at 0 it is 1.
  function automatic step_t next_step(input logic [31:0] v, input logic d,
                                      input logic [31:0] max);
    step_t r;
    if (!d) begin
      if (v < max) r = '{value: v + 32'd1, dir: 1'b0};
      else         r = '{value: max - 32'd1, dir: 1'b1};
    end else begin
      if (v != 32'd0) r = '{value: v - 32'd1, dir: 1'b1};
      else            r = '{value: 32'd1, dir: 1'b0};
    end
    return r;
  endfunction

endpackage

// File: rtl/contador_predictor.sv
// Combinational next(v,d) of the bouncing counter at WIDTH bits.
module contador_predictor
  import contador_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH
) (
  input  logic [WIDTH-1:0] v,
  input  logic             d,
  output logic [WIDTH-1:0] next_v,
  output logic             next_d
);

  step_t s;

  always_comb begin
    s      = next_step(32'(v), d, max_of(WIDTH));
    next_v = WIDTH'(s.value);
    next_d = s.dir;
  end

endmodule

// File: rtl/contador_monitor.sv
// Receive-side checker for the up/down bouncing counter: acquires lock,
// predicts the next sample, flags mismatches and counts completed periods.
module contador_monitor
  import contador_pkg::*;
#(
  parameter int unsigned WIDTH    = DEF_WIDTH,
  parameter int unsigned LOCK_LEN = 3,
  parameter int unsigned LOSS_LEN = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             en,
  input  logic [WIDTH-1:0] c_in,
  output logic             locked,
  output logic             direcao,
  output logic [WIDTH-1:0] expected,
  output logic             err,
  output logic [7:0]       err_count,
  output logic [15:0]      period_count
);

  localparam logic [WIDTH-1:0] MAX    = WIDTH'(max_of(WIDTH));
  localparam logic [WIDTH-1:0] ONE    = WIDTH'(1);
  localparam int unsigned      STEP_W = $clog2(LOCK_LEN + 1);
  localparam int unsigned      MISS_W = $clog2(LOSS_LEN + 1);

  state_t              state_q, state_d;
  logic [WIDTH-1:0]    prev_q, prev_d;
  logic [WIDTH-1:0]    expected_q, expected_d;
  logic                dir_q, dir_d;
  logic                exp_dir_q, exp_dir_d;
  logic                err_q, err_d;
  logic [7:0]          err_count_q, err_count_d;
  logic [15:0]         period_count_q, period_count_d;
  logic [STEP_W-1:0]   step_q, step_d;
  logic [MISS_W-1:0]   miss_q, miss_d;

  logic [WIDTH-1:0]    pred_v, ahead_v, ahead_in_v;
  logic                pred_d, ahead_d, ahead_in_d;
  logic                step_up, step_dn, is_step, step_dir;
  logic                consistent, mismatch, lock_hit, loss_hit;

  // What the stream should do after the last accepted value.
  contador_predictor #(.WIDTH(WIDTH)) u_pred_cur (
    .v      (prev_q),
    .d      (dir_q),
    .next_v (pred_v),
    .next_d (pred_d)
  );

  // One step beyond the value being accepted this cycle; becomes the new expected.
  contador_predictor #(.WIDTH(WIDTH)) u_pred_ahead (
    .v      (ahead_in_v),
    .d      (ahead_in_d),
    .next_v (ahead_v),
    .next_d (ahead_d)
  );

  always_comb begin
    step_up    = (prev_q != MAX) && (c_in == prev_q + ONE);
    step_dn    = (prev_q != '0) && (c_in == prev_q - ONE);
    is_step    = step_up | step_dn;
    step_dir   = step_dn;
    consistent = is_step && ((step_q == '0) || ((c_in == pred_v) && (step_dir == pred_d)));
    mismatch   = (c_in != expected_q);
    lock_hit   = consistent && (step_q == STEP_W'(LOCK_LEN - 1));
    loss_hit   = mismatch && (miss_q == MISS_W'(LOSS_LEN - 1));
    if (state_q == LOCKED) begin
      ahead_in_v = expected_q;
      ahead_in_d = exp_dir_q;
    end else begin
      ahead_in_v = c_in;
      ahead_in_d = step_dir;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values, whatever order the simulator evaluates the blocks in.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state_q <= UNSYNC;
    else        state_q <= state_d;
  end

  // NOTE: every signal gets a default at the top of each always_comb, so no
  // path through the case statements can leave it unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    if (en) begin
      unique case (state_q)
        UNSYNC:  state_d = ACQUIRE;
        ACQUIRE: if (lock_hit) state_d = LOCKED;
        LOCKED:  if (loss_hit) state_d = UNSYNC;
        default: state_d = UNSYNC;
      endcase
    end
  end

  always_comb begin
    prev_d         = prev_q;
    dir_d          = dir_q;
    expected_d     = expected_q;
    exp_dir_d      = exp_dir_q;
    step_d         = step_q;
    miss_d         = miss_q;
    err_d          = 1'b0;
    err_count_d    = err_count_q;
    period_count_d = period_count_q;
    if (en) begin
      unique case (state_q)
        UNSYNC: begin
          prev_d = c_in;
          step_d = '0;
          miss_d = '0;
        end
        ACQUIRE: begin
          prev_d = c_in;
          if (consistent) begin
            step_d = step_q + STEP_W'(1);
            dir_d  = step_dir;
            if (lock_hit) begin
              expected_d = ahead_v;
              exp_dir_d  = ahead_d;
              miss_d     = '0;
            end
          end else begin
            step_d = is_step ? STEP_W'(1) : '0;
            if (is_step) dir_d = step_dir;
          end
        end
        LOCKED: begin
          // On a match c_in equals expected_q, so matched and flywheel steps
          // advance the prediction identically; only bookkeeping differs.
          prev_d     = expected_q;
          dir_d      = exp_dir_q;
          expected_d = ahead_v;
          exp_dir_d  = ahead_d;
          if (mismatch) begin
            err_d = 1'b1;
            if (err_count_q != 8'hFF) err_count_d = err_count_q + 8'd1;
            if (loss_hit) begin
              miss_d = '0;
              step_d = '0;
            end else begin
              miss_d = miss_q + MISS_W'(1);
            end
          end else begin
            miss_d = '0;
            if ((c_in == '0) && dir_q) period_count_d = period_count_q + 16'd1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      prev_q         <= '0;
      dir_q          <= 1'b0;
      expected_q     <= '0;
      exp_dir_q      <= 1'b0;
      step_q         <= '0;
      miss_q         <= '0;
      err_q          <= 1'b0;
      err_count_q    <= '0;
      period_count_q <= '0;
    end else begin
      prev_q         <= prev_d;
      dir_q          <= dir_d;
      expected_q     <= expected_d;
      exp_dir_q      <= exp_dir_d;
      step_q         <= step_d;
      miss_q         <= miss_d;
      err_q          <= err_d;
      err_count_q    <= err_count_d;
      period_count_q <= period_count_d;
    end
  end

  always_comb begin
    locked       = (state_q == LOCKED);
    direcao      = dir_q;
    expected     = expected_q;
    err          = err_q;
    err_count    = err_count_q;
    period_count = period_count_q;
  end

endmodule
